// File: rtl/lag_tile_injector.sv
// Tile-side wormhole injector: queues packet descriptors, picks a free entry PL
// round-robin and streams head/body/tail flits onto the tile din slot.
module lag_tile_injector #(
   parameter int XS       = 4,
   parameter int YS       = 4,
   parameter int NPLE     = 2,
   parameter int DATA_W   = 32,
   parameter int MAX_LEN  = 16,
   parameter int DQ_DEPTH = 4,
   localparam int XW = (XS > 1) ? $clog2(XS) : 1,
   localparam int YW = (YS > 1) ? $clog2(YS) : 1,
   localparam int PW = (NPLE > 1) ? $clog2(NPLE) : 1,
   localparam int LW = $clog2(MAX_LEN + 1),
   localparam int FW = 3 + PW + XW + YW + DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              desc_valid,
   output logic              desc_ready,
   input  logic [XW-1:0]     desc_x,
   input  logic [YW-1:0]     desc_y,
   input  logic [LW-1:0]     desc_len,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [NPLE-1:0]   full_flag,
   output logic [FW-1:0]     flit_out,
   output logic [31:0]       pkt_count,
   output logic [31:0]       flit_count,
   output logic              busy
);

   localparam int QW = $clog2(DQ_DEPTH);
   localparam int CW = $clog2(DQ_DEPTH + 1);

   typedef struct packed {
      logic              valid;
      logic              head;
      logic              tail;
      logic [PW-1:0]     pl;
      logic [XW-1:0]     xdest;
      logic [YW-1:0]     ydest;
      logic [DATA_W-1:0] data;
   } flit_t;

   typedef enum logic [1:0] {IDLE, SEL, SEND} state_t;

   logic [XW-1:0] q_x   [DQ_DEPTH];
   logic [YW-1:0] q_y   [DQ_DEPTH];
   logic [LW-1:0] q_len [DQ_DEPTH];
   logic [QW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;

   state_t        state;
   logic [PW-1:0] pl, last_pl, sel_pl, cand;
   logic          sel_found;
   logic [XW-1:0] dest_x;
   logic [YW-1:0] dest_y;
   logic [LW-1:0] remaining;
   logic          first;
   logic          is_tail;
   flit_t         flit_reg;
   logic          push, pop, fire, q_empty, len_ok;

   assign desc_ready = (count != CW'(DQ_DEPTH));
   assign len_ok     = (desc_len != '0) && (desc_len <= LW'(MAX_LEN));
   assign push       = desc_valid && desc_ready && len_ok;
   assign q_empty    = (count == '0);
   assign pop        = (state == SEL) && sel_found && !q_empty;
   assign fire       = (state == SEND) && data_valid && !full_flag[pl];
   assign is_tail    = (remaining == LW'(1));
   assign data_ready = fire;
   assign busy       = (state != IDLE) || !q_empty;
   assign flit_out   = flit_reg;

   // Round-robin search starting just after the PL used by the previous packet.
   always_comb begin
      sel_found = 1'b0;
      sel_pl    = '0;
      cand      = '0;
      for (int k = 1; k <= NPLE; k++) begin
         cand = PW'((int'(last_pl) + k) % NPLE);
         if (!sel_found && !full_flag[cand]) begin
            sel_found = 1'b1;
            sel_pl    = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_x[wr_ptr]   <= desc_x;
         q_y[wr_ptr]   <= desc_y;
         q_len[wr_ptr] <= desc_len;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + QW'(1);
         if (pop)  rd_ptr <= rd_ptr + QW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // Once a PL is latched it is held until the tail; a full PL stalls the packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pl         <= '0;
         last_pl    <= PW'(NPLE - 1);
         dest_x     <= '0;
         dest_y     <= '0;
         remaining  <= '0;
         first      <= 1'b0;
         flit_reg   <= '0;
         flit_count <= '0;
         pkt_count  <= '0;
      end else begin
         flit_reg <= '0;
         case (state)
            IDLE: begin
               if (!q_empty || push) state <= SEL;
            end
            SEL: begin
               if (pop) begin
                  pl        <= sel_pl;
                  dest_x    <= q_x[rd_ptr];
                  dest_y    <= q_y[rd_ptr];
                  remaining <= q_len[rd_ptr];
                  first     <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (fire) begin
                  flit_reg   <= '{valid: 1'b1, head: first, tail: is_tail, pl: pl,
                                  xdest: dest_x, ydest: dest_y, data: data_in};
                  first      <= 1'b0;
                  remaining  <= remaining - LW'(1);
                  flit_count <= flit_count + 32'd1;
                  if (is_tail) begin
                     pkt_count <= pkt_count + 32'd1;
                     last_pl   <= pl;
                     state     <= (!q_empty || push) ? SEL : IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lag_tile_injector.sv
// Directed bench for lag_tile_injector: a per-cycle vector table for the basic
// packets, then hand sequences for round-robin, stall, queue limits and reset.
module tb_lag_tile_injector;

   logic        clk;
   logic        rst_n;
   logic        desc_valid;
   logic        desc_ready;
   logic [1:0]  desc_x;
   logic [1:0]  desc_y;
   logic [4:0]  desc_len;
   logic        data_valid;
   logic        data_ready;
   logic [31:0] data_in;
   logic [1:0]  full_flag;
   logic [39:0] flit_out;
   logic [31:0] pkt_count;
   logic [31:0] flit_count;
   logic        busy;

   int vectors;
   int miscompares;

   typedef struct {
      logic        dv;
      logic [1:0]  dx;
      logic [1:0]  dy;
      logic [4:0]  dl;
      logic [39:0] eflit;
      logic        edr;
      logic        ebusy;
   } vec_t;

   vec_t tbl[$];

   lag_tile_injector #(
      .XS(4), .YS(4), .NPLE(2), .DATA_W(32), .MAX_LEN(16), .DQ_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_x(desc_x), .desc_y(desc_y), .desc_len(desc_len),
      .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
      .full_flag(full_flag), .flit_out(flit_out),
      .pkt_count(pkt_count), .flit_count(flit_count), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flit layout: {valid, head, tail, pl, xdest[1:0], ydest[1:0], data[31:0]}
   function automatic logic [39:0] mk(input logic v, input logic h, input logic t,
                                      input logic p, input logic [1:0] x,
                                      input logic [1:0] y, input logic [31:0] d);
      return {v, h, t, p, x, y, d};
   endfunction

   task automatic addVec(input logic dv, input logic [1:0] dx, input logic [1:0] dy,
                         input logic [4:0] dl, input logic [39:0] ef,
                         input logic edr, input logic eb);
      vec_t v;
      v.dv = dv; v.dx = dx; v.dy = dy; v.dl = dl;
      v.eflit = ef; v.edr = edr; v.ebusy = eb;
      tbl.push_back(v);
   endtask

   task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      desc_valid = v.dv;
      desc_x     = v.dx;
      desc_y     = v.dy;
      desc_len   = v.dl;
      data_in    = 32'hA000_0000 + 32'(idx);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pushDesc(input logic [1:0] x, input logic [1:0] y, input logic [4:0] len);
      desc_valid = 1'b1;
      desc_x     = x;
      desc_y     = y;
      desc_len   = len;
      nextCycle();
      desc_valid = 1'b0;
   endtask

   task automatic waitFlit(output logic [39:0] f);
      bit got;
      got = 1'b0;
      f   = '0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (flit_out[39] === 1'b1) begin
            f   = flit_out;
            got = 1'b1;
         end
      end
      if (!got) checkOutput("flit_timeout", 64'd0, 64'd1);
   endtask

   logic [39:0] f;
   logic [39:0] exp_f;
   logic        exp_dr;

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      desc_valid = 1'b0; desc_x = '0; desc_y = '0; desc_len = '0;
      data_valid = 1'b0; data_in = '0; full_flag = '0;

      // Single 3-flit packet then a 1-flit packet, cycle by cycle
      addVec(1'b1, 2'd2, 2'd1, 5'd3, 40'h0, 1'b0, 1'b0);
      addVec(1'b0, 2'd0, 2'd0, 5'd0, 40'h0, 1'b0, 1'b1);
      addVec(1'b0, 2'd0, 2'd0, 5'd0, 40'h0, 1'b1, 1'b1);
      addVec(1'b0, 2'd0, 2'd0, 5'd0, mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 32'hA000_0002), 1'b1, 1'b1);
      addVec(1'b0, 2'd0, 2'd0, 5'd0, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 32'hA000_0003), 1'b1, 1'b1);
      addVec(1'b0, 2'd0, 2'd0, 5'd0, mk(1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'd1, 32'hA000_0004), 1'b0, 1'b0);
      addVec(1'b0, 2'd0, 2'd0, 5'd0, 40'h0, 1'b0, 1'b0);
      addVec(1'b1, 2'd3, 2'd3, 5'd1, 40'h0, 1'b0, 1'b0);
      addVec(1'b0, 2'd0, 2'd0, 5'd0, 40'h0, 1'b0, 1'b1);
      addVec(1'b0, 2'd0, 2'd0, 5'd0, 40'h0, 1'b1, 1'b1);
      addVec(1'b0, 2'd0, 2'd0, 5'd0, mk(1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 2'd3, 32'hA000_0009), 1'b0, 1'b0);

      #12;
      checkOutput("reset_flit", 64'(flit_out), 64'd0);
      checkOutput("reset_desc_ready", 64'(desc_ready), 64'd1);
      checkOutput("reset_data_ready", 64'(data_ready), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_counts", {pkt_count, flit_count}, 64'd0);
      rst_n = 1'b1;
      nextCycle();

      data_valid = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i], i);
         @(negedge clk);
         checkOutput($sformatf("tbl%0d_flit", i), 64'(flit_out), 64'(tbl[i].eflit));
         checkOutput($sformatf("tbl%0d_data_ready", i), 64'(data_ready), 64'(tbl[i].edr));
         checkOutput($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].ebusy));
         nextCycle();
      end
      checkOutput("tbl_pkt_count", 64'(pkt_count), 64'd2);
      checkOutput("tbl_flit_count", 64'(flit_count), 64'd4);

      // Round-robin: last PL was 1, so three 1-flit packets go 0,1,0
      data_in = 32'h1234_5678;
      pushDesc(2'd1, 2'd0, 5'd1);
      pushDesc(2'd2, 2'd0, 5'd1);
      pushDesc(2'd3, 2'd0, 5'd1);
      for (int i = 0; i < 3; i++) begin
         waitFlit(f);
         checkOutput($sformatf("rr_free_%0d", i), 64'(f),
                     64'(mk(1'b1, 1'b1, 1'b1, 1'(i % 2 == 1), 2'(i + 1), 2'd0, 32'h1234_5678)));
      end

      // PL 0 full throughout: every packet lands on PL 1
      full_flag = 2'b01;
      pushDesc(2'd1, 2'd1, 5'd1);
      pushDesc(2'd2, 2'd1, 5'd1);
      pushDesc(2'd3, 2'd1, 5'd1);
      for (int i = 0; i < 3; i++) begin
         waitFlit(f);
         checkOutput($sformatf("rr_pl0_full_%0d", i), 64'(f),
                     64'(mk(1'b1, 1'b1, 1'b1, 1'b1, 2'(i + 1), 2'd1, 32'h1234_5678)));
      end

      // Mid-packet stall: PL 0 full for cycles 4..8 after flit 2 fires in cycle 3
      nextCycle();
      full_flag = 2'b00;
      pushDesc(2'd1, 2'd2, 5'd4);
      for (int c = 1; c <= 11; c++) begin
         data_in   = 32'hB000_0000 + 32'(c);
         full_flag = (c >= 4 && c <= 8) ? 2'b01 : 2'b00;
         exp_dr    = (c == 2 || c == 3 || c == 9 || c == 10);
         case (c)
            3:       exp_f = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd2, 32'hB000_0002);
            4:       exp_f = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 32'hB000_0003);
            10:      exp_f = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd2, 32'hB000_0009);
            11:      exp_f = mk(1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 32'hB000_000A);
            default: exp_f = '0;
         endcase
         @(negedge clk);
         checkOutput($sformatf("stall_c%0d_flit", c), 64'(flit_out), 64'(exp_f));
         checkOutput($sformatf("stall_c%0d_data_ready", c), 64'(data_ready), 64'(exp_dr));
         nextCycle();
      end
      checkOutput("stall_pkt_count", 64'(pkt_count), 64'd9);
      checkOutput("stall_flit_count", 64'(flit_count), 64'd14);

      // Queue: illegal lengths dropped, then fill the queue while all PLs are full
      full_flag  = 2'b11;
      data_in    = 32'hC0DE_0000;
      desc_valid = 1'b1;
      desc_len   = 5'd0;
      nextCycle();
      desc_len   = 5'd17;
      nextCycle();
      desc_valid = 1'b0;
      @(negedge clk);
      checkOutput("drop_busy", 64'(busy), 64'd0);
      checkOutput("drop_desc_ready", 64'(desc_ready), 64'd1);
      nextCycle();
      for (int c = 0; c < 5; c++) begin
         desc_valid = 1'b1;
         desc_x     = 2'(c);
         desc_y     = 2'd0;
         desc_len   = 5'd1;
         @(negedge clk);
         checkOutput($sformatf("queue_desc_ready_%0d", c), 64'(desc_ready), 64'(c < 4));
         nextCycle();
      end
      desc_valid = 1'b0;
      full_flag  = 2'b00;
      for (int i = 0; i < 4; i++) begin
         waitFlit(f);
         checkOutput($sformatf("queue_flit_%0d", i), 64'(f),
                     64'(mk(1'b1, 1'b1, 1'b1, 1'(i % 2 == 0), 2'(i), 2'd0, 32'hC0DE_0000)));
      end
      checkOutput("queue_drained_busy", 64'(busy), 64'd0);
      checkOutput("queue_flit_count", 64'(flit_count), 64'd18);
      checkOutput("queue_pkt_count", 64'(pkt_count), 64'd13);

      // Reset in the middle of a 6-flit packet
      nextCycle();
      data_in = 32'hD00D_0000;
      pushDesc(2'd2, 2'd2, 5'd6);
      waitFlit(f);
      waitFlit(f);
      checkOutput("pre_reset_flit2", 64'(f), 64'(mk(1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd2, 32'hD00D_0000)));
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_flit", 64'(flit_out), 64'd0);
      checkOutput("midrst_counts", {pkt_count, flit_count}, 64'd0);
      checkOutput("midrst_desc_ready", 64'(desc_ready), 64'd1);
      checkOutput("midrst_data_ready", 64'(data_ready), 64'd0);
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      nextCycle();
      pushDesc(2'd1, 2'd3, 5'd1);
      waitFlit(f);
      checkOutput("post_reset_flit", 64'(f), 64'(mk(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 2'd3, 32'hD00D_0000)));
      checkOutput("post_reset_counts", {pkt_count, flit_count}, {32'd1, 32'd1});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
